lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Downstream consumer of the 26-bit Galois LFSR generator; receives its parallel state word each enabled cycle.
- Independently predicts the next state, acquires lock on the sequence, and counts words that break it.
- Used as the receive-side PRBS checker in loopback and link self-test.

Parameters:
- LOCK_CNT, 4, consecutive correct predictions required to declare lock (1..15).
- UNLOCK_CNT, 3, consecutive mispredicted words that drop lock (1..15).
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  din carries a valid sample this cycle.
- din  input  [1:26]  sampled LFSR state word; bit 26 is the serial output / feedback bit.
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle strobe per mispredicted word while LOCKED.
- err_cnt  output  [ERR_W-1:0]  saturating count of mispredicted words.

Behaviour:
- Prediction function nxt(s), purely combinational:
  - s == 0 -> 26'b1 (only bit 26 set).
  - Otherwise: n[1]=s[26]; n[2]=s[1]^s[26]; n[3:7]=s[2:6]; n[8]=s[7]^s[26]; n[9]=s[8]^s[26]; n[10:26]=s[9:25].
- Internal registers: prev[1:26] (last reference word), match counter, miss counter, 2-bit state.
- Reset (rst=1 at clock edge): state=HUNT, prev=0, counters=0, locked=0, err_pulse=0, err_cnt=0. Reset overrides all other inputs, including mid-lock.
- en=0: all state, prev and counters hold; err_pulse=0. Gaps in en are transparent to the checker.
- HUNT, on en: prev<=din; match=0; go SYNC.
- SYNC, on en:
  - din==nxt(prev): match+1; if match+1==LOCK_CNT, go LOCKED with miss=0.
  - Otherwise: match<=0, stay in SYNC.
  - prev<=din in both cases (re-seed on every word).
- LOCKED, on en:
  - din==nxt(prev): prev<=din; miss<=0.
  - Otherwise (flywheel): prev<=nxt(prev), so the corrupted word is not adopted; err_pulse<=1; err_cnt increments; miss+1.
  - If miss+1==UNLOCK_CNT: go HUNT, clear counters; this final error is still counted and pulsed.
- Output timing:
  - locked is registered and equals (state==LOCKED).
  - It rises on the cycle after the enabled sample that completes lock.
  - err_pulse is high for exactly the cycle after each erroring sample.
- err_cnt saturates at all-ones and does not wrap.
- clr_err has priority over increment; clr_err together with an error in the same cycle gives err_cnt=1.
- Errors are counted only in LOCKED. SYNC mismatches are not errors.
- An all-zero din is treated as an ordinary word: nxt(0)=26'b1, so a zero word followed by 26'b1 counts as a match.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and random din -> locked=0, err_pulse=0, err_cnt=0; then rst=0.
- Acquisition: clean stream from seed 26'b1, en=1 every cycle -> locked=1 on the cycle after the 5th word (1 seed + LOCK_CNT=4 matches); err_cnt stays 0 over 1000 further words.
- Single hit: when locked, flip din[26] on one word -> err_pulse high exactly 1 cycle, err_cnt=1, locked stays 1; the following clean word matches with no further pulse.
- Loss of lock: corrupt 3 consecutive words -> 3 pulses, err_cnt=3, locked falls after the 3rd; clean stream -> relocks after 5 more valid words, err_cnt still 3.
- Gapped and zero input:
  - Clean stream with en randomly low ~50% -> lock acquired, no errors.
  - Inject din=0 followed by din=26'b1 during SYNC -> counts as a match.
- Saturation and clear:
  - ERR_W=3 with 10 isolated single-word errors (UNLOCK_CNT not reached) -> err_cnt stops at 7.
  - clr_err asserted on an error cycle -> err_cnt=1 on the next cycle.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// Sample stream into the PRBS checker and its lock/error status back out.
// The master drives the samples; the checker is the slave.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);
  logic             en;
  logic [1:26]      din;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, din, clr_err,
    input  locked, err_pulse, err_cnt
  );

  modport slave (
    input  en, din, clr_err,
    output locked, err_pulse, err_cnt
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker for the 26-bit Galois LFSR.
// It predicts each next state word, locks onto the sequence and counts mispredicted words.
module lfsr_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [3:0] LOCK_N   = LOCK_CNT[3:0];
  localparam logic [3:0] UNLOCK_N = UNLOCK_CNT[3:0];

  function automatic logic [1:26] nxt(input logic [1:26] s);
    logic [1:26] n;
    if (s == '0) begin
      n = 26'b1;
    end else begin
      n[1]      = s[26];
      n[2]      = s[1] ^ s[26];
      n[3:7]    = s[2:6];
      n[8]      = s[7] ^ s[26];
      n[9]      = s[8] ^ s[26];
      n[10:26]  = s[9:25];
    end
    return n;
  endfunction

  state_t           state_reg, state_next;
  logic [1:26]      prev_reg, prev_next;
  logic [3:0]       match_reg, match_next;
  logic [3:0]       miss_reg, miss_next;
  logic             locked_reg, locked_next;
  logic             err_pulse_reg, err_pulse_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic [1:26]      predicted;
  logic             hit;
  logic             err_inc;

  assign predicted = nxt(prev_reg);
  assign hit       = (bus.din == predicted);

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    match_next     = match_reg;
    miss_next      = miss_reg;
    err_pulse_next = 1'b0;
    err_inc        = 1'b0;
    if (bus.en) begin
      case (state_reg)
        HUNT: begin
          prev_next  = bus.din;
          match_next = '0;
          state_next = SYNC;
        end
        SYNC: begin
          // Re-seed on every word so a single bad word only costs one restart.
          prev_next = bus.din;
          if (hit) begin
            if (match_reg + 4'd1 == LOCK_N) begin
              state_next = LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              match_next = match_reg + 4'd1;
            end
          end else begin
            match_next = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            prev_next = bus.din;
            miss_next = '0;
          end else begin
            // Flywheel: keep our own prediction rather than adopting the corrupted word.
            prev_next      = predicted;
            err_pulse_next = 1'b1;
            err_inc        = 1'b1;
            if (miss_reg + 4'd1 == UNLOCK_N) begin
              state_next = HUNT;
              miss_next  = '0;
              match_next = '0;
            end else begin
              miss_next = miss_reg + 4'd1;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end

    locked_next = (state_next == LOCKED);

    err_cnt_next = err_cnt_reg;
    if (bus.clr_err) begin
      err_cnt_next = err_inc ? ERR_W'(1) : '0;
    end else if (err_inc && (err_cnt_reg != '1)) begin
      err_cnt_next = err_cnt_reg + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      prev_reg      <= '0;
      match_reg     <= '0;
      miss_reg      <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      match_reg     <= match_next;
      miss_reg      <= miss_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign bus.locked    = locked_reg;
  assign bus.err_pulse = err_pulse_reg;
  assign bus.err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: two instances share stimulus, one with a 3-bit
// error counter so saturation can be observed alongside the full-width counter.
module tb_lfsr_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:26] din;
  logic        clr_err;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [1:26] cur;
  logic [1:26] flip;

  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(16)) bus_a ();
  lfsr_checker_if #(.ERR_W(3))  bus_b ();

  assign bus_a.en = en;
  assign bus_a.din = din;
  assign bus_a.clr_err = clr_err;
  assign bus_b.en = en;
  assign bus_b.din = din;
  assign bus_b.clr_err = clr_err;

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  // Reference next-state: right shift of the [1:26] word with bit 26 fed back into taps 1, 2, 8, 9.
  function automatic logic [1:26] ref_nxt(input logic [1:26] s);
    logic [1:26] n;
    logic        fb;
    if (s == '0) return 26'b1;
    fb = s[26];
    n  = s >> 1;
    n[1] = fb;
    n[2] = n[2] ^ fb;
    n[8] = n[8] ^ fb;
    n[9] = n[9] ^ fb;
    return n;
  endfunction

  task automatic step(input logic e, input logic [1:26] d, input logic c);
    en = e;
    din = d;
    clr_err = c;
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%b en=%b din=%07h clr=%b -> locked=%b pulse=%b cnt=%0d cnt3=%0d",
             cyc, rst, e, d, c, bus_a.locked, bus_a.err_pulse, bus_a.err_cnt, bus_b.err_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b1, 26'($urandom()), 1'b0);
    total++;
    if ({bus_a.locked, bus_a.err_pulse, bus_a.err_cnt} !== 18'd0) begin
      bad++;
      $display("FAIL reset_a: got locked=%b pulse=%b cnt=%0d want 0 0 0", bus_a.locked, bus_a.err_pulse, bus_a.err_cnt);
    end
    total++;
    if ({bus_b.locked, bus_b.err_pulse, bus_b.err_cnt} !== 5'd0) begin
      bad++;
      $display("FAIL reset_b: got locked=%b pulse=%b cnt=%0d want 0 0 0", bus_b.locked, bus_b.err_pulse, bus_b.err_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    int pulses = 0;
    cur = 26'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, cur, 1'b0);
      cur = ref_nxt(cur);
      if (k >= 4) begin
        total++;
        if (bus_a.locked !== (k == 5)) begin
          bad++;
          $display("FAIL acq_locked_w%0d: got %b want %b", k, bus_a.locked, (k == 5));
        end
      end
    end
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, cur, 1'b0);
      cur = ref_nxt(cur);
      if (bus_a.err_pulse || !bus_a.locked) pulses++;
    end
    total++;
    if (pulses != 0 || bus_a.err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL acq_clean_run: got %0d bad cycles cnt=%0d want 0 and 0", pulses, bus_a.err_cnt);
    end
  endtask

  task automatic test_single_hit();
    step(1'b1, cur ^ flip, 1'b0);
    cur = ref_nxt(cur);
    total++;
    if ({bus_a.locked, bus_a.err_pulse, bus_a.err_cnt} !== {2'b11, 16'd1}) begin
      bad++;
      $display("FAIL hit_err: got locked=%b pulse=%b cnt=%0d want 1 1 1", bus_a.locked, bus_a.err_pulse, bus_a.err_cnt);
    end
    step(1'b0, 26'h2AA_AAAA, 1'b0);
    total++;
    if ({bus_a.locked, bus_a.err_pulse, bus_a.err_cnt} !== {2'b10, 16'd1}) begin
      bad++;
      $display("FAIL hit_gap: got locked=%b pulse=%b cnt=%0d want 1 0 1", bus_a.locked, bus_a.err_pulse, bus_a.err_cnt);
    end
    step(1'b1, cur, 1'b0);
    cur = ref_nxt(cur);
    total++;
    if ({bus_a.locked, bus_a.err_pulse, bus_a.err_cnt} !== {2'b10, 16'd1}) begin
      bad++;
      $display("FAIL hit_recover: got locked=%b pulse=%b cnt=%0d want 1 0 1", bus_a.locked, bus_a.err_pulse, bus_a.err_cnt);
    end
  endtask

  task automatic test_loss_of_lock();
    step(1'b0, '0, 1'b1);
    total++;
    if (bus_a.err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL lol_clear: got cnt=%0d want 0", bus_a.err_cnt);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, cur ^ 26'h155_5555, 1'b0);
      cur = ref_nxt(cur);
      total++;
      if ({bus_a.locked, bus_a.err_pulse, bus_a.err_cnt} !== {(i < 3), 1'b1, 16'(i)}) begin
        bad++;
        $display("FAIL lol_corrupt_%0d: got locked=%b pulse=%b cnt=%0d want %b 1 %0d",
                 i, bus_a.locked, bus_a.err_pulse, bus_a.err_cnt, (i < 3), i);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, cur, 1'b0);
      cur = ref_nxt(cur);
      total++;
      if ({bus_a.locked, bus_a.err_pulse, bus_a.err_cnt} !== {(k == 5), 1'b0, 16'd3}) begin
        bad++;
        $display("FAIL lol_relock_w%0d: got locked=%b pulse=%b cnt=%0d want %b 0 3",
                 k, bus_a.locked, bus_a.err_pulse, bus_a.err_cnt, (k == 5));
      end
    end
  endtask

  task automatic test_gapped();
    int n = 0;
    int cycles = 0;
    logic e;
    do_reset();
    cur = 26'b1;
    while (n < 8 && cycles < 200) begin
      e = 1'($urandom_range(0, 1));
      if (e) begin
        step(1'b1, cur, 1'b0);
        cur = ref_nxt(cur);
        n++;
      end else begin
        step(1'b0, 26'($urandom()), 1'b0);
      end
      cycles++;
      total++;
      if ({bus_a.locked, bus_a.err_pulse, bus_a.err_cnt} !== {(n >= 5), 1'b0, 16'd0}) begin
        bad++;
        $display("FAIL gap_c%0d_n%0d: got locked=%b pulse=%b cnt=%0d want %b 0 0",
                 cycles, n, bus_a.locked, bus_a.err_pulse, bus_a.err_cnt, (n >= 5));
      end
    end
    total++;
    if (n < 8) begin
      bad++;
      $display("FAIL gap_budget: got %0d enabled words want 8", n);
    end
  endtask

  task automatic test_zero_word();
    do_reset();
    step(1'b1, 26'h155_5555, 1'b0);
    step(1'b1, '0, 1'b0);
    cur = 26'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, cur, 1'b0);
      cur = ref_nxt(cur);
      if (k >= 3) begin
        total++;
        if (bus_a.locked !== (k == 4)) begin
          bad++;
          $display("FAIL zero_match_w%0d: got locked=%b want %b", k, bus_a.locked, (k == 4));
        end
      end
    end
  endtask

  task automatic test_saturation();
    int exp_b;
    do_reset();
    total++;
    if ({bus_a.locked, bus_b.locked} !== 2'b00) begin
      bad++;
      $display("FAIL sat_midlock_reset: got locked_a=%b locked_b=%b want 0 0", bus_a.locked, bus_b.locked);
    end
    cur = 26'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, cur, 1'b0);
      cur = ref_nxt(cur);
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, cur ^ flip, 1'b0);
      cur = ref_nxt(cur);
      exp_b = (i > 7) ? 7 : i;
      total++;
      if (bus_a.err_cnt !== 16'(i) || bus_b.err_cnt !== 3'(exp_b) || !bus_b.locked || !bus_b.err_pulse) begin
        bad++;
        $display("FAIL sat_err_%0d: got cnt=%0d cnt3=%0d locked3=%b pulse3=%b want %0d %0d 1 1",
                 i, bus_a.err_cnt, bus_b.err_cnt, bus_b.locked, bus_b.err_pulse, i, exp_b);
      end
      step(1'b1, cur, 1'b0);
      cur = ref_nxt(cur);
    end
    step(1'b1, cur ^ flip, 1'b1);
    cur = ref_nxt(cur);
    total++;
    if (bus_a.err_cnt !== 16'd1 || bus_b.err_cnt !== 3'd1 || !bus_a.err_pulse) begin
      bad++;
      $display("FAIL sat_clr_on_err: got cnt=%0d cnt3=%0d pulse=%b want 1 1 1", bus_a.err_cnt, bus_b.err_cnt, bus_a.err_pulse);
    end
  endtask

  initial begin
    flip = 26'b1;
    rst = 1'b1;
    en = 1'b0;
    din = '0;
    clr_err = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_acquire();
    test_single_hit();
    test_loss_of_lock();
    test_gapped();
    test_zero_word();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
